// File: rtl/seg_scan_capture_pkg.sv
// Shared constants, scan-bus payload type and helpers for the 7-segment scan capture block.
package seg_scan_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned DIG_IDX_W  = 3;
  localparam int unsigned FRAME_W    = NUM_DIGITS * BCD_W;
  localparam int unsigned TO_CNT_W   = 16;

  // Standard lit-segment patterns, bit 0 = segment a.
  localparam logic [SEG_W-1:0] SEG_PAT_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_PAT_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_PAT_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_PAT_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_PAT_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_PAT_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_PAT_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_PAT_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_PAT_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_PAT_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_PAT_OFF = 7'h00;

  localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;
  localparam logic [BCD_W-1:0] BCD_BAD   = 4'hE;

  // One synced, polarity-normalized observation of the scan bus.
  typedef struct packed {
    logic [NUM_DIGITS-1:0] en;
    logic [SEG_W-1:0]      seg;
    logic                  dp;
  } scan_vec_t;

  // Index of the active enable; only meaningful when exactly one bit is set.
  function automatic logic [DIG_IDX_W-1:0] onehot_idx(input logic [NUM_DIGITS-1:0] en);
    logic [DIG_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (en[i]) begin
        idx = idx | DIG_IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // True when two or more enables are active at once.
  function automatic logic multi_hot(input logic [NUM_DIGITS-1:0] en);
    return |(en & (en - NUM_DIGITS'(1)));
  endfunction

endpackage

// File: rtl/seg_scan_capture_seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD decoder; all-off is blank, unknown patterns flag bad.
module seg7_to_bcd
  import seg_scan_pkg::*;
(
  input  logic [SEG_W-1:0] i_seg,
  output logic [BCD_W-1:0] o_bcd_c,
  output logic             o_bad_c
);

  // Exact-match lookup against the standard digit patterns.
  always_comb begin
    o_bcd_c = BCD_BAD;
    o_bad_c = 1'b0;
    case (i_seg)
      SEG_PAT_0:   o_bcd_c = 4'd0;
      SEG_PAT_1:   o_bcd_c = 4'd1;
      SEG_PAT_2:   o_bcd_c = 4'd2;
      SEG_PAT_3:   o_bcd_c = 4'd3;
      SEG_PAT_4:   o_bcd_c = 4'd4;
      SEG_PAT_5:   o_bcd_c = 4'd5;
      SEG_PAT_6:   o_bcd_c = 4'd6;
      SEG_PAT_7:   o_bcd_c = 4'd7;
      SEG_PAT_8:   o_bcd_c = 4'd8;
      SEG_PAT_9:   o_bcd_c = 4'd9;
      SEG_PAT_OFF: o_bcd_c = BCD_BLANK;
      default: begin
        o_bcd_c = BCD_BAD;
        o_bad_c = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of the multiplexed 7-segment scan bus: syncs the pins, waits for a stable
// pattern, decodes it to BCD and reassembles 8-digit frames published with a valid pulse.
// Optional macro SEG_SCAN_TIMEOUT_EN builds a no-sample timeout driving 'stale'.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int unsigned STABLE_CYC     = 4,
  parameter int unsigned EN_ACTIVE_LOW  = 0,
  parameter int unsigned SEG_ACTIVE_LOW = 0
`ifdef SEG_SCAN_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC    = 65535
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEG_W-1:0]      seg_in,
  input  logic                  dp_in,
  input  logic [NUM_DIGITS-1:0] disp_en_in,
  output logic [FRAME_W-1:0]    digits,
  output logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  frame_valid,
  output logic                  frame_bad,
  output logic                  multi_en_err,
  output logic                  stale
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);

  // Pin levels meaning "nothing lit / no digit selected"; the synchronizers reset to
  // these so an active-low bus does not look like all digits enabled after reset.
  localparam logic [NUM_DIGITS-1:0] EN_IDLE  = {NUM_DIGITS{EN_ACTIVE_LOW != 0}};
  localparam logic [SEG_W-1:0]      SEG_IDLE = {SEG_W{SEG_ACTIVE_LOW != 0}};
  localparam logic                  DP_IDLE  = (SEG_ACTIVE_LOW != 0);

  logic [SEG_W-1:0]      r_seg_s1, r_seg_s2;
  logic                  r_dp_s1, r_dp_s2;
  logic [NUM_DIGITS-1:0] r_en_s1, r_en_s2;

  scan_vec_t             w_vec;
  scan_vec_t             r_prev_vec;
  logic [CNT_W-1:0]      r_stab_cnt;
  logic [CNT_W-1:0]      w_stab_cnt_nxt;
  logic                  w_strobe;

  logic                  w_en_none;
  logic                  w_en_multi;
  logic                  w_en_single;
  logic [DIG_IDX_W-1:0]  w_idx;
  logic [BCD_W-1:0]      w_bcd;
  logic                  w_bad;
  logic                  w_publish;

  logic [FRAME_W-1:0]    r_shadow;
  logic [NUM_DIGITS-1:0] r_shadow_dp;
  logic [NUM_DIGITS-1:0] r_shadow_bad;
  logic [NUM_DIGITS-1:0] r_seen;

  logic [FRAME_W-1:0]    r_digits;
  logic [NUM_DIGITS-1:0] r_dp_mask;
  logic                  r_frame_valid;
  logic                  r_frame_bad;
  logic                  r_multi_en_err;

  // Two-flop synchronizers on every scan-bus pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1 <= SEG_IDLE;
      r_seg_s2 <= SEG_IDLE;
      r_dp_s1  <= DP_IDLE;
      r_dp_s2  <= DP_IDLE;
      r_en_s1  <= EN_IDLE;
      r_en_s2  <= EN_IDLE;
    end else begin
      r_seg_s1 <= seg_in;
      r_seg_s2 <= r_seg_s1;
      r_dp_s1  <= dp_in;
      r_dp_s2  <= r_dp_s1;
      r_en_s1  <= disp_en_in;
      r_en_s2  <= r_en_s1;
    end
  end

  // Normalize polarity so 1 always means enabled / lit.
  always_comb begin
    w_vec     = '0;
    w_vec.en  = r_en_s2 ^ EN_IDLE;
    w_vec.seg = r_seg_s2 ^ SEG_IDLE;
    w_vec.dp  = r_dp_s2 ^ DP_IDLE;
  end

  // Run-length of the current synced vector; saturates one above the strobe point so the
  // strobe value is only ever reached once per run.
  always_comb begin
    w_stab_cnt_nxt = r_stab_cnt;
    if (w_vec != r_prev_vec) begin
      w_stab_cnt_nxt = '0;
    end else if (r_stab_cnt != CNT_W'(STABLE_CYC)) begin
      w_stab_cnt_nxt = r_stab_cnt + CNT_W'(1);
    end
  end

  assign w_strobe = (w_stab_cnt_nxt == CNT_W'(STABLE_CYC - 1));

  // Stability tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_vec <= '0;
      r_stab_cnt <= '0;
    end else begin
      r_prev_vec <= w_vec;
      r_stab_cnt <= w_stab_cnt_nxt;
    end
  end

  // Enable classification for the sampled vector.
  assign w_en_none   = (w_vec.en == '0);
  assign w_en_multi  = multi_hot(w_vec.en);
  assign w_en_single = !w_en_none && !w_en_multi;
  assign w_idx       = onehot_idx(w_vec.en);

  seg7_to_bcd u_dec (
    .i_seg   (w_vec.seg),
    .o_bcd_c (w_bcd),
    .o_bad_c (w_bad)
  );

  // Digit 0 of a new scan closes the previous frame if every digit was seen.
  assign w_publish = w_strobe && w_en_single && (w_idx == '0) && (r_seen == '1);

  // Shadow frame assembly and seen-mask bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow     <= '0;
      r_shadow_dp  <= '0;
      r_shadow_bad <= '0;
      r_seen       <= '0;
    end else if (w_strobe) begin
      if (w_en_multi) begin
        r_seen <= '0;
      end else if (w_en_single) begin
        r_shadow[{w_idx, 2'b00} +: BCD_W] <= w_bcd;
        r_shadow_dp[w_idx]                <= w_vec.dp;
        r_shadow_bad[w_idx]               <= w_bad;
        if (w_idx == '0) begin
          r_seen <= NUM_DIGITS'(1);
        end else begin
          r_seen[w_idx] <= 1'b1;
        end
      end
    end
  end

  // Published frame, held between publishes, plus the single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits       <= '1;
      r_dp_mask      <= '0;
      r_frame_bad    <= 1'b0;
      r_frame_valid  <= 1'b0;
      r_multi_en_err <= 1'b0;
    end else begin
      r_frame_valid  <= w_publish;
      r_multi_en_err <= w_strobe && w_en_multi;
      if (w_publish) begin
        r_digits    <= r_shadow;
        r_dp_mask   <= r_shadow_dp;
        r_frame_bad <= |r_shadow_bad;
      end
    end
  end

  assign digits       = r_digits;
  assign dp_mask      = r_dp_mask;
  assign frame_valid  = r_frame_valid;
  assign frame_bad    = r_frame_bad;
  assign multi_en_err = r_multi_en_err;

`ifdef SEG_SCAN_TIMEOUT_EN
  logic [TO_CNT_W-1:0] r_to_cnt;
  logic [TO_CNT_W-1:0] w_to_cnt_nxt;
  logic                r_stale;

  // Cycles since the last valid single-digit sample, saturating.
  always_comb begin
    w_to_cnt_nxt = r_to_cnt;
    if (w_strobe && w_en_single) begin
      w_to_cnt_nxt = '0;
    end else if (r_to_cnt != '1) begin
      w_to_cnt_nxt = r_to_cnt + TO_CNT_W'(1);
    end
  end

  // Timeout counter and registered stale flag tracking it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_stale  <= 1'b0;
    end else begin
      r_to_cnt <= w_to_cnt_nxt;
      r_stale  <= (32'(w_to_cnt_nxt) >= TIMEOUT_CYC);
    end
  end

  assign stale = r_stale;
`else
  assign stale = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: directed scans plus randomized scans compared
// against a per-sample frame model. Define SEG_SCAN_TIMEOUT_EN to also exercise 'stale'.
module tb_seg_scan_capture;

  localparam int unsigned STAB = 4;
  localparam int          SLOT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic        dp_in;
  logic [7:0]  disp_en_in;
  logic [31:0] digits;
  logic [7:0]  dp_mask;
  logic        frame_valid;
  logic        frame_bad;
  logic        multi_en_err;
  logic        stale;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  seg_scan_capture #(
    .STABLE_CYC(STAB)
`ifdef SEG_SCAN_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(100)
`endif
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_in       (seg_in),
    .dp_in        (dp_in),
    .disp_en_in   (disp_en_in),
    .digits       (digits),
    .dp_mask      (dp_mask),
    .frame_valid  (frame_valid),
    .frame_bad    (frame_bad),
    .multi_en_err (multi_en_err),
    .stale        (stale)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode: standard digit patterns, all-off blank, anything else bad.
  logic [6:0] pat_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [6:0] bad_tab [4]  = '{7'h49, 7'h01, 7'h40, 7'h76};

  function automatic logic [3:0] ref_decode(input logic [6:0] s);
    if (s == 7'h00) return 4'hF;
    for (int d = 0; d < 10; d++) begin
      if (pat_tab[d] == s) return 4'(d);
    end
    return 4'hE;
  endfunction

  // Frame-level model state and expected-frame queues.
  logic [3:0]  m_dig [8];
  logic [7:0]  m_dp;
  logic [7:0]  m_bad;
  logic [7:0]  m_seen;
  int          m_multi = 0;
  logic [31:0] q_dig [$];
  logic [7:0]  q_dp  [$];
  logic        q_bad [$];

  int obs_frames = 0;
  int obs_multi  = 0;

  // One stable observation of the bus, applied with the capture rules.
  task automatic model_sample(input logic [7:0] en, input logic [6:0] s, input logic dp);
    int          idx;
    logic [31:0] f;
    if (en == 8'h00) return;
    if ($countones(en) != 1) begin
      m_multi++;
      m_seen = 8'h00;
      return;
    end
    idx = 0;
    for (int i = 0; i < 8; i++) if (en[i]) idx = i;
    if (idx == 0) begin
      if (m_seen == 8'hFF) begin
        f = '0;
        for (int i = 0; i < 8; i++) f[4*i +: 4] = m_dig[i];
        q_dig.push_back(f);
        q_dp.push_back(m_dp);
        q_bad.push_back(m_bad != 8'h00);
      end
      m_seen = 8'h00;
    end
    m_dig[idx]  = ref_decode(s);
    m_dp[idx]   = dp;
    m_bad[idx]  = (ref_decode(s) == 4'hE);
    m_seen[idx] = 1'b1;
  endtask

  task automatic drive(input logic [7:0] en, input logic [6:0] s, input logic dp, input int n);
    disp_en_in = en;
    seg_in     = s;
    dp_in      = dp;
    repeat (n) @(negedge clk);
  endtask

  // A scan slot; with glitch the pattern is broken for 2 cycles in the middle.
  task automatic slot(input logic [7:0] en, input logic [6:0] s, input logic dp,
                      input int len, input bit glitch);
    if (glitch) begin
      model_sample(en, s, dp);
      drive(en, s, dp, 6);
      drive(en, ~s, dp, 2);
      model_sample(en, s, dp);
      drive(en, s, dp, len);
    end else begin
      if (len >= int'(STAB)) model_sample(en, s, dp);
      drive(en, s, dp, len);
    end
  endtask

  logic [6:0] cur_seg [8];
  logic       cur_dp  [8];

  task automatic run_scan(input int glitch_at, input int bad_at, input int multi_before,
                          input int last_digit);
    for (int d = 0; d <= last_digit; d++) begin
      logic [6:0] s;
      s = (d == bad_at) ? 7'h49 : cur_seg[d];
      if (d == multi_before) slot(8'h03, 7'h00, 1'b0, 10, 1'b0);
      slot(8'(1 << d), s, cur_dp[d], SLOT, d == glitch_at);
    end
  endtask

  logic [31:0] e_dig;
  logic [7:0]  e_dp;
  logic        e_bad;

  // Output monitor: every frame_valid pulse must match the next modelled frame.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_valid) begin
        obs_frames++;
        if (q_dig.size() == 0) begin
          check_val("spurious_frame", 32'(frame_valid), 32'd0);
        end else begin
          e_dig = q_dig.pop_front();
          e_dp  = q_dp.pop_front();
          e_bad = q_bad.pop_front();
          check_val("frame_digits", digits, e_dig);
          check_val("frame_dp", 32'(dp_mask), 32'(e_dp));
          check_val("frame_bad", 32'(frame_bad), 32'(e_bad));
        end
      end
      if (multi_en_err) obs_multi++;
    end
  end

  initial begin
    int f0;
    cur_seg = '{7'h06, 7'h5B, 7'h00, 7'h4F, 7'h66, 7'h00, 7'h6D, 7'h7D};
    cur_dp  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
    m_dp = '0; m_bad = '0; m_seen = '0;

    rst_n = 1'b0;
    drive(8'h00, 7'h00, 1'b0, 3);
    check_val("rst_digits", digits, 32'hFFFF_FFFF);
    check_val("rst_dp_mask", 32'(dp_mask), 32'd0);
    check_val("rst_frame_valid", 32'(frame_valid), 32'd0);
    check_val("rst_frame_bad", 32'(frame_bad), 32'd0);
    check_val("rst_multi", 32'(multi_en_err), 32'd0);
    check_val("rst_stale", 32'(stale), 32'd0);
    rst_n = 1'b1;
    drive(8'h00, 7'h00, 1'b0, 4);

    // Two clean scans give exactly one frame.
    run_scan(-1, -1, -1, 7);
    run_scan(-1, -1, -1, 7);
    check_val("t1_frames", 32'(obs_frames), 32'd1);
    check_val("t1_digits", digits, 32'h65F4_3F21);
    check_val("t1_dp_mask", 32'(dp_mask), 32'h02);
    check_val("t1_frame_bad", 32'(frame_bad), 32'd0);

    // Bad pattern on digit 3, then two clean scans.
    run_scan(-1, 3, -1, 7);
    run_scan(-1, -1, -1, 7);
    check_val("t2_bad_nibble", 32'(digits[15:12]), 32'hE);
    check_val("t2_bad_flag", 32'(frame_bad), 32'd1);
    run_scan(-1, -1, -1, 7);
    check_val("t2_clean_flag", 32'(frame_bad), 32'd0);
    check_val("t2_clean_digits", digits, 32'h65F4_3F21);

    // Two enables at once abort the frame being collected.
    run_scan(-1, -1, 4, 7);
    check_val("t3_multi", 32'(obs_multi), 32'd1);
    f0 = obs_frames;
    run_scan(-1, -1, -1, 7);
    check_val("t3_no_publish", 32'(obs_frames), 32'(f0));
    run_scan(-1, -1, -1, 7);
    check_val("t3_publish", 32'(obs_frames), 32'(f0 + 1));

    // Short glitch inside a slot leaves the frame unchanged.
    run_scan(4, -1, -1, 7);
    run_scan(-1, -1, -1, 7);
    check_val("t4_digits", digits, 32'h65F4_3F21);
    check_val("t4_dp_mask", 32'(dp_mask), 32'h02);

    // Reset pulse mid-scan.
    run_scan(-1, -1, -1, 3);
    drive(8'h00, 7'h00, 1'b0, 6);
    check_val("t5_pending", 32'(q_dig.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    check_val("t5_digits", digits, 32'hFFFF_FFFF);
    check_val("t5_dp_mask", 32'(dp_mask), 32'd0);
    check_val("t5_frame_bad", 32'(frame_bad), 32'd0);
    check_val("t5_frame_valid", 32'(frame_valid), 32'd0);
    m_seen = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    f0 = obs_frames;
    run_scan(-1, -1, -1, 7);
    check_val("t5_no_frame", 32'(obs_frames), 32'(f0));
    run_scan(-1, -1, -1, 7);
    check_val("t5_first_frame", 32'(obs_frames), 32'(f0 + 1));

`ifdef SEG_SCAN_TIMEOUT_EN
    // Long gap raises stale; the next single-digit sample clears it.
    drive(8'h00, 7'h00, 1'b0, 60);
    check_val("t6_not_stale", 32'(stale), 32'd0);
    drive(8'h00, 7'h00, 1'b0, 60);
    check_val("t6_stale", 32'(stale), 32'd1);
    run_scan(-1, -1, -1, 0);
    check_val("t6_stale_clear", 32'(stale), 32'd0);
    run_scan(-1, -1, -1, 7);
`endif

    // Randomized scans with blanks, bad patterns, dp, glitches, gaps and multi-enable slots.
    for (int s = 0; s < 40; s++) begin
      for (int d = 0; d < 8; d++) begin
        int         r;
        int         a;
        int         b;
        logic [6:0] sg;
        logic [7:0] me;
        if ($urandom_range(0, 29) == 0)
          slot(8'h00, 7'h00, 1'b0, int'($urandom_range(1, 8)), 1'b0);
        if ($urandom_range(0, 39) == 0) begin
          a  = int'($urandom_range(0, 7));
          b  = (a + int'($urandom_range(1, 7))) % 8;
          me = 8'(1 << a) | 8'(1 << b);
          slot(me, 7'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(STAB + 1, 12)), 1'b0);
        end
        r = int'($urandom_range(0, 99));
        if (r < 8)       sg = bad_tab[$urandom_range(0, 3)];
        else if (r < 20) sg = 7'h00;
        else             sg = pat_tab[$urandom_range(0, 9)];
        slot(8'(1 << d), sg, 1'($urandom_range(0, 3) == 0),
             int'($urandom_range(STAB + 2, 20)), $urandom_range(0, 15) == 0);
      end
    end
    slot(8'h01, pat_tab[0], 1'b0, SLOT, 1'b0);
    drive(8'h00, 7'h00, 1'b0, 20);

    check_val("end_pending", 32'(q_dig.size()), 32'd0);
    check_val("end_multi", 32'(obs_multi), 32'(m_multi));
    check_val("end_stale", 32'(stale), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
